// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: default widths, NOP encoding and the instruction/PC/valid packet.
package cpu_pkg;
  localparam int CPU_PC_W    = 8;
  localparam int CPU_INSTR_W = 12;

  localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 12'h000;

  typedef struct packed {
    logic [CPU_INSTR_W-1:0] instr;
    logic [CPU_PC_W-1:0]    pc;
    logic                   valid;
  } fetch_pkt_t;

  localparam fetch_pkt_t NOP_PKT = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
endpackage

// File: rtl/fetch_skid_buffer.sv
// 1-entry skid holding a returning read while the pipe is stopped; loads in 1 cycle,
// drains when the consumer takes it; flush has priority over load and drain.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       drain_i,
  input  logic       flush_i,
  input  fetch_pkt_t pkt_i,
  output fetch_pkt_t pkt_o
);

  fetch_pkt_t pkt_q, pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (flush_i) begin
      pkt_d = NOP_PKT;
    end else if (load_i) begin
      pkt_d       = pkt_i;
      pkt_d.valid = 1'b1;
    end else if (drain_i) begin
      pkt_d = NOP_PKT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_q <= NOP_PKT;
    else       pkt_q <= pkt_d;
  end

  assign pkt_o = pkt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, synchronous imem read, 2-cycle issue-to-output latency.
// Stall holds the output and parks the in-flight read in the skid; redirect flushes everything.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = CPU_PC_W,    // must match cpu_pkg packet widths
  parameter int              INSTR_W  = CPU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            issue;
  fetch_pkt_t      out_q, out_d;
  fetch_pkt_t      ret_pkt, skid_pkt;

  assign issue     = ~stall & ~redirect_valid;
  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;

  assign ret_pkt = '{instr: imem_rdata, pc: inflight_pc_q, valid: inflight_q};

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (~redirect_valid & stall & inflight_q),
    .drain_i (~redirect_valid & ~stall & skid_pkt.valid),
    .flush_i (redirect_valid),
    .pkt_i   (ret_pkt),
    .pkt_o   (skid_pkt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (issue)     fetch_pc_d = fetch_pc_q + PC_W'(1);
  end

  // Skid is older than any in-flight read, so it always wins the output slot.
  always_comb begin
    out_d = out_q;
    if (redirect_valid) begin
      out_d = NOP_PKT;
    end else if (!stall) begin
      if (skid_pkt.valid)  out_d = skid_pkt;
      else if (inflight_q) out_d = ret_pkt;
      else                 out_d = NOP_PKT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_q         <= NOP_PKT;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      out_q <= out_d;
    end
  end

  assign instr_out   = out_q.instr;
  assign instr_valid = out_q.valid;
  assign pc_out      = out_q.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: queue-based fetch model plus literal checkpoints.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata = 12'h000;
  logic [11:0] instr_out;
  logic        instr_valid;
  logic [7:0]  pc_out;

  logic        w_en;
  logic [7:0]  w_addr;
  logic [11:0] w_rdata = 12'h000;
  logic [11:0] w_instr;
  logic        w_valid;
  logic [7:0]  w_pc;

  int checks = 0;
  int errors = 0;
  int cycle  = -2;

  logic [11:0] rom [256];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.PC_W(8), .INSTR_W(12), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
    .pc_out(pc_out)
  );

  instruction_fetch_unit #(.PC_W(8), .INSTR_W(12), .RESET_PC(8'hFE)) dut_w (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(8'h00), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr_out(w_instr), .instr_valid(w_valid),
    .pc_out(w_pc)
  );

  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];
  always @(posedge clk) if (w_en)    w_rdata    <= rom[w_addr];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cycle, got, exp);
    end
  endtask

  // Model: every issued address joins a queue; an unstalled cycle moves the oldest
  // queued address to the output, a stall freezes everything, redirect/reset empty it.
  logic [7:0] m_pc  = 8'h00;
  logic [7:0] m_q[$];
  logic       m_vld = 1'b0;
  logic [7:0] m_opc = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 8'h00; m_q.delete(); m_vld = 1'b0; m_opc = 8'h00;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_q.delete(); m_vld = 1'b0; m_opc = 8'h00;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        m_opc = m_q.pop_front();
        m_vld = 1'b1;
      end else begin
        m_opc = 8'h00;
        m_vld = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 8'h01;
    end
  end

  always @(negedge clk) begin
    chk("instr_valid", int'(instr_valid), int'(m_vld));
    chk("pc_out", int'(pc_out), m_vld ? int'(m_opc) : 0);
    chk("instr_out", int'(instr_out), m_vld ? int'(rom[m_opc]) : 0);
    chk("imem_en", int'(imem_en), int'(!stall && !redirect_valid));
    chk("imem_addr", int'(imem_addr), int'(m_pc));
    if (!reset)
      chk("skid_overflow", int'(dut.skid_pkt.valid & dut.inflight_q & stall), 0);
  end

  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [7:0] rpc);
    @(negedge clk);
    #1;
    cycle++;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
  endtask

  initial begin
    logic       rst_c, st_c, rv_c;
    logic [7:0] rpc_c;
    for (int i = 0; i < 256; i++) rom[i] = 12'(i + 12'h100);

    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c <= 42; c++) begin
      rst_c = (c == 34 || c == 35);
      st_c  = (c >= 5 && c <= 7) || (c >= 22 && c <= 25) || (c >= 32 && c <= 34);
      rv_c  = (c == 14 || c == 24);
      rpc_c = (c == 14) ? 8'h40 : (c == 24) ? 8'h80 : 8'h00;
      cyc(rst_c, st_c, rv_c, rpc_c);
      #1;
      case (c)
        0:  chk("wrap_addr0", int'(w_addr), 'hFE);
        1:  begin chk("first_invalid", int'(instr_valid), 0); chk("wrap_addr1", int'(w_addr), 'hFF); end
        2:  begin
              chk("first_valid", int'(instr_valid), 1);
              chk("first_pc", int'(pc_out), 0);
              chk("first_instr", int'(instr_out), 'h100);
              chk("wrap_pc_fe", int'(w_pc), 'hFE);
              chk("wrap_instr_fe", int'(w_instr), 'h1FE);
              chk("wrap_addr2", int'(w_addr), 'h00);
            end
        3:  begin chk("pc1", int'(pc_out), 1); chk("wrap_pc_ff", int'(w_pc), 'hFF); end
        4:  begin chk("wrap_pc_00", int'(w_pc), 0); chk("wrap_instr_00", int'(w_instr), 'h100); end
        5:  begin chk("stall_pc3", int'(pc_out), 3); chk("wrap_pc_01", int'(w_pc), 1); end
        6, 7, 8: chk("held_pc3", int'(pc_out), 3);
        9:  chk("skid_pc4", int'(pc_out), 4);
        10: chk("after_skid_pc5", int'(pc_out), 5);
        11: chk("after_skid_instr6", int'(instr_out), 'h106);
        15, 16: begin
              chk("redir_bubble_vld", int'(instr_valid), 0);
              chk("redir_bubble_pc", int'(pc_out), 0);
              chk("redir_bubble_instr", int'(instr_out), 0);
            end
        17: begin chk("redir_pc40", int'(pc_out), 'h40); chk("redir_instr140", int'(instr_out), 'h140); end
        18: chk("redir_pc41", int'(pc_out), 'h41);
        24: begin chk("held_vld", int'(instr_valid), 1); chk("held_pc45", int'(pc_out), 'h45); end
        25: chk("flush_in_stall_vld", int'(instr_valid), 0);
        27: chk("restart_bubble_vld", int'(instr_valid), 0);
        28: begin chk("restart_pc80", int'(pc_out), 'h80); chk("restart_instr180", int'(instr_out), 'h180); end
        34: begin
              chk("async_rst_vld", int'(instr_valid), 0);
              chk("async_rst_pc", int'(pc_out), 0);
              chk("async_rst_instr", int'(instr_out), 0);
            end
        37: chk("post_rst_invalid", int'(instr_valid), 0);
        38: begin chk("post_rst_pc0", int'(pc_out), 0); chk("post_rst_instr", int'(instr_out), 'h100); end
        39: chk("post_rst_pc1", int'(pc_out), 1);
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that generates the program counter and reads 12-bit instructions from a synchronous instruction memory. It presents a registered instruction/valid/PC triple to the IF/ID pipeline register and honours the same pipeline stop signal. A 1-entry skid buffer absorbs the in-flight memory read when a stall arrives, so no instruction is lost or duplicated. Branch/jump redirects from later stages flush in-flight work and restart fetch.

Parameters:
PC_W, 8, program-counter / instruction-memory address width (word addressed)
INSTR_W, 12, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
stall  input  1  pipeline stop; same signal that drives the IF/ID register hold
redirect_valid  input  1  branch/jump taken; single-cycle pulse
redirect_pc  input  PC_W  new fetch address, sampled when redirect_valid=1
imem_en  output  1  memory read enable
imem_addr  output  PC_W  memory read address
imem_rdata  input  INSTR_W  read data, valid exactly 1 cycle after imem_en=1
instr_out  output  INSTR_W  instruction to IF/ID register; NOP (all zeros) when instr_valid=0
instr_valid  output  1  instr_out holds a real instruction
pc_out  output  PC_W  address of instr_out; 0 when instr_valid=0

Behaviour:
- Reset (async): fetch_pc=RESET_PC; inflight=0; skid_valid=0; instr_out=0, instr_valid=0, pc_out=0. The imem_en combinational output is 1 during reset, but the issued read is discarded.
- Issue: imem_en = ~stall & ~redirect_valid; imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc+1 (mod 2^PC_W, wraps to 0 silently); inflight <= 1; inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- Latency: an address issued in cycle t returns in t+1 and appears on instr_out/instr_valid in cycle t+2. After reset release, first valid output is RESET_PC, 2 cycles later.
- Return, stall=0: output register <= skid contents if skid_valid (skid clears), otherwise imem_rdata if inflight, otherwise NOP/valid=0.
  - Skid drain and a new returning read cannot coincide, because issue was blocked while the skid filled.
- Return, stall=1: the output register holds. An in-flight return is written to the skid (skid_valid<=1, with its PC).
  - Skid overflow is impossible by construction; the verifier asserts skid_valid & inflight & stall never occurs.
- Stall release: the skid drains to the output in the same cycle a new fetch issues. No bubble and no reordering.
- Redirect (priority over stall):
  - fetch_pc <= redirect_pc; inflight and skid invalidated; output register <= NOP, valid=0; no issue that cycle.
  - Redirect in cycle t: issue at redirect_pc in t+1 (if not stalled), valid output in t+3.
  - The bubble count is fixed at 2 cycles of instr_valid=0 when unstalled.
- Redirect and stall together: the flush still happens. Fetch restarts when stall clears.
- Back-to-back redirects: the last one wins; each one flushes.
- Instruction content is opaque; no decode or halt detection in this block.
- State: {fetch_pc, inflight, inflight_pc, skid_valid, skid_instr, skid_pc, output regs}. There is no separate encoded FSM. Modes are RUN (issuing), HELD (stall, skid maybe full) and FLUSH (redirect cycle).

Decomposition:
- Shared package cpu_pkg: INSTR_W, PC_W defaults, NOP_INSTR constant (12'h000), typedef fetch_pkt_t {instr, pc, valid}.
- One sub-module: fetch_skid_buffer (1-entry, load/drain/flush inputs, fetch_pkt_t in/out).
- PC increment and output register stay in the top.

Test Plan:
- Straight line: ROM[i]=i+12'h100, no stall. Reset released at cycle 0 → instr_out 0x100,0x101,0x102… with pc_out 0,1,2…, valid from cycle 2, one per cycle.
- Stall for 3 cycles while inflight. Stall asserted when pc_out=3 → output holds 3 for 3 cycles; skid captures 4; after release, 4,5,6 follow with no gap and no duplicate.
- Redirect: redirect_valid pulse with redirect_pc=0x40 while streaming → exactly 2 invalid (NOP, pc 0) cycles, then 0x40,0x41…; the old in-flight instruction never appears.
- Redirect during stall with skid full → skid discarded; after stall release the first valid instruction is from redirect_pc; no stale PC is ever output.
- Wrap: RESET_PC=0xFE → pc_out sequence 0xFE,0xFF,0x00,0x01; imem_addr wraps identically.
- Reset asserted mid-stream with skid full → outputs 0 immediately (async); after release, fetch restarts at RESET_PC with the same 2-cycle latency.
